uart_tx_buffered: RTL and testbench
===================================

Name: uart_tx_buffered

Overview:
- Serial transmitter directly downstream of getReqFSM.
- Consumes its txdata/ldtxdata byte stream, returns txempty, and drives an 8N1 UART line (LSB first) to the WiFi module.
- Double-buffered: a transmit holding register (THR) feeds a transmit shift register (TSR), so the next byte can be accepted while the current one shifts.

Parameters:
- CLKS_PER_BIT, 5208: clock cycles per bit (50 MHz / 9600 baud); must be >= 2. Benches use 4.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- txdata  in  8  byte to send, sampled when ldtxdata = 1
- ldtxdata  in  1  load strobe, one cycle
- txempty  out  1  THR empty; a new byte may be loaded
- tx  out  1  serial line, idle high, registered
- txbusy  out  1  TSR currently shifting a frame
- overrun  out  1  one-cycle pulse when a byte is dropped

Behaviour:
- Reset (rst_n = 0 at an edge): tx = 1, txempty = 1, txbusy = 0, overrun = 0, THR and TSR cleared, FSM = IDLE, counters = 0.
  - Reset mid-frame truncates the frame; tx is high after that edge.
- Load:
  - ldtxdata = 1 with txempty = 1 at edge N: THR <= txdata; txempty = 0 after edge N.
  - Guarantees getReqFSM's waitload/waitsend sequence sees txempty low before it re-samples.
- Transfer:
  - In IDLE with THR full: THR moves to TSR at the next edge, and txempty returns to 1 at that edge.
  - Start bit: tx = 0 after that same edge. Load at N with idle shifter therefore gives start bit and txempty = 1 from edge N+1.
- FSM states: IDLE, START, DATA, STOP.
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - Baud counter counts 0..CLKS_PER_BIT-1 and restarts on every state entry.
  - START -> DATA after 1 bit time.
  - DATA shifts bits 0..7 (3-bit index), then -> STOP.
  - STOP holds tx = 1 for 1 bit time. On its last cycle:
    - THR full: transfer and go directly to START (zero idle gap, txempty -> 1).
    - THR empty: go to IDLE.
- txbusy = 1 in START/DATA/STOP, 0 in IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Overrun:
  - ldtxdata = 1 while txempty = 0 and no transfer is occurring that cycle: byte dropped, THR unchanged, overrun = 1 for one cycle.
- Simultaneous load and transfer (ldtxdata in the same cycle THR moves to TSR): the new byte is accepted into THR, no overrun, txempty stays 0.
- ldtxdata held high for multiple cycles: first cycle loads; subsequent cycles count as overruns unless a transfer frees THR.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum (IDLE, START, DATA, STOP)
  - DEFAULT_CLKS_PER_BIT = 5208
  - DATA_BITS = 8, FRAME_BITS = 10
- Sub-module uart_baud_gen (parameter CLKS_PER_BIT; inputs clk, rst_n, restart; output tick on last cycle of a bit). Instantiated once.

Test Plan (CLKS_PER_BIT = 4):
- Reset, then idle 20 cycles -> tx = 1, txempty = 1, txbusy = 0, overrun never asserted.
- Load 0x47 once -> txempty low one cycle, then high.
  - tx, 4 cycles per bit: 0, 1,1,1,0,0,0,1,0, 1; then 1 thereafter.
  - txbusy high exactly 40 cycles.
- Load 0x47, then 0x45 once txempty = 1 -> two frames with no idle gap (80 cycles of txbusy).
  - Second frame data bits 1,0,1,0,0,0,1,0.
- Load 0x41, 0x42, 0x43 on three consecutive cycles -> 0x41 and 0x42 sent, 0x43 dropped, overrun pulses once on the third-load cycle.
- Assert rst_n = 0 during DATA bit 3 of 0x55 -> tx = 1 and txempty = 1 after that edge; no further transitions until the next load.
- Drive getReqFSM into this block (start pulse) -> 19 back-to-back frames decoded on tx match the request bytes in order.
  - done asserts only after the 19th load is accepted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered 8N1 UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 5208;
  localparam int DATA_BITS            = 8;
  localparam int FRAME_BITS           = 10;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter with a holding register (THR) in front of the shift register (TSR),
// so the next byte can be accepted while the current frame shifts out.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] txdata,
  input  logic       ldtxdata,
  output logic       txempty,
  output logic       tx,
  output logic       txbusy,
  output logic       overrun
);

  tx_state_t r_state;
  tx_state_t w_next_state;
  logic [7:0] r_thr;
  logic [7:0] r_tsr;
  logic [2:0] r_bit_idx;
  logic       r_tx;
  logic       r_txempty;
  logic       r_txbusy;
  logic       r_overrun;
  logic       w_tick;
  logic       w_transfer;
  logic       w_load_ok;
  logic       w_shift;
  logic       w_tx_next;

  // Counter is held at zero while idle, so START always begins a fresh bit time;
  // every later state entry coincides with the counter wrapping on its tick.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(r_state == IDLE),
    .tick   (w_tick)
  );

  always_comb begin
    w_next_state = r_state;
    w_transfer   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_txempty) begin
          w_transfer   = 1'b1;
          w_next_state = START;
        end
      end
      START: begin
        if (w_tick) w_next_state = DATA;
      end
      DATA: begin
        if (w_tick && r_bit_idx == 3'(DATA_BITS - 1)) w_next_state = STOP;
      end
      STOP: begin
        if (w_tick) begin
          if (!r_txempty) begin
            w_transfer   = 1'b1;
            w_next_state = START;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // A transfer frees the THR in the same cycle, so a coincident load is accepted.
  assign w_load_ok = ldtxdata && (r_txempty || w_transfer);
  assign w_shift   = (r_state == DATA) && w_tick;

  // Line value for the next cycle; when a data bit ends the following bit is r_tsr[1].
  always_comb begin
    w_tx_next = 1'b1;
    case (w_next_state)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift ? r_tsr[1] : r_tsr[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_thr     <= '0;
      r_tsr     <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
      r_txempty <= 1'b1;
      r_txbusy  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_tx      <= w_tx_next;
      r_txbusy  <= (w_next_state != IDLE);
      r_overrun <= ldtxdata && !w_load_ok;

      if (w_load_ok) begin
        r_thr     <= txdata;
        r_txempty <= 1'b0;
      end else if (w_transfer) begin
        r_txempty <= 1'b1;
      end

      if (w_transfer) begin
        r_tsr <= r_thr;
      end else if (w_shift) begin
        r_tsr <= {1'b0, r_tsr[7:1]};
      end

      if (r_state == START) begin
        r_bit_idx <= '0;
      end else if (w_shift) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  assign tx      = r_tx;
  assign txempty = r_txempty;
  assign txbusy  = r_txbusy;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: directed frames plus a randomized byte stream, decoded off the line.
module tb_uart_tx_buffered;
  import uart_pkg::*;

  localparam int CPB = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] txdata;
  logic       ldtxdata;
  logic       txempty;
  logic       tx;
  logic       txbusy;
  logic       overrun;

  uart_tx_buffered #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .txdata  (txdata),
    .ldtxdata(ldtxdata),
    .txempty (txempty),
    .tx      (tx),
    .txbusy  (txbusy),
    .overrun (overrun)
  );

  // ---------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic mon_en = 1'b1;
  int busy_cnt = 0;
  int busy_falls = 0;
  int ovr_cnt = 0;
  logic prev_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected line level for frame bit position idx: start, 8 data LSB first, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 1 && idx <= DATA_BITS) return b[idx-1];
    return 1'b1;
  endfunction

  // Activity counters sampled on the falling edge.
  always @(negedge clk) begin
    if (txbusy) busy_cnt++;
    if (prev_busy && !txbusy) busy_falls++;
    prev_busy = txbusy;
    if (overrun) ovr_cnt++;
  end

  // Line decoder: detect start bit, sample each bit at its middle.
  initial begin
    logic [7:0] b;
    logic sbit, stop;
    forever begin
      @(negedge clk);
      if (rst_n && tx == 1'b0) begin
        repeat (CPB/2) @(negedge clk);
        sbit = tx;
        for (int bi = 0; bi < DATA_BITS; bi++) begin
          repeat (CPB) @(negedge clk);
          b[bi] = tx;
        end
        repeat (CPB) @(negedge clk);
        stop = tx;
        if (mon_en) begin
          chk("rx_start_bit", {31'b0, sbit}, 32'd0);
          chk("rx_stop_bit", {31'b0, stop}, 32'd1);
          rx_q.push_back(b);
        end
      end
    end
  end

  // ---------------- driver tasks
  task automatic clear_counters();
    busy_cnt   = 0;
    busy_falls = 0;
    ovr_cnt    = 0;
  endtask

  // Presents b for exactly one rising edge; returns just after that edge.
  task automatic load_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    txdata   = b;
    ldtxdata = 1'b1;
    @(posedge clk);
    #1;
    ldtxdata = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (txempty !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_empty_timeout"}, {31'b0, (n < 1000)}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((txbusy !== 1'b0 || txempty !== 1'b1) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle_timeout"}, {31'b0, (n < 5000)}, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic compare_rx(input string tag);
    chk({tag, "_byte_count"}, rx_q.size(), exp_q.size());
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      chk({tag, "_byte"}, {24'b0, rx_q.pop_front()}, {24'b0, exp_q.pop_front()});
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  // ---------------- stimulus
  initial begin
    int lows;
    logic [7:0] b;
    rst_n    = 1'b0;
    ldtxdata = 1'b0;
    txdata   = 8'h00;

    // Reset values, then 20 idle cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_txempty", {31'b0, txempty}, 32'd1);
    chk("rst_txbusy", {31'b0, txbusy}, 32'd0);
    chk("rst_overrun", {31'b0, overrun}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_counters();
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || txempty !== 1'b1 || txbusy !== 1'b0) lows++;
    end
    chk("idle_outputs_stable", lows, 0);
    chk("idle_no_overrun", ovr_cnt, 0);

    // Single byte 0x47: exact waveform, 4 cycles per bit.
    clear_counters();
    load_byte(8'h47);
    exp_q.push_back(8'h47);
    @(negedge clk);
    chk("load_txempty_low", {31'b0, txempty}, 32'd0);
    chk("load_tx_still_idle", {31'b0, tx}, 32'd1);
    for (int i = 0; i < FRAME_BITS * CPB; i++) begin
      @(negedge clk);
      chk($sformatf("frame47_c%0d", i), {31'b0, tx}, {31'b0, frame_bit(8'h47, i / CPB)});
      if (i == 0) chk("transfer_txempty_high", {31'b0, txempty}, 32'd1);
    end
    @(negedge clk);
    chk("after_frame_tx_high", {31'b0, tx}, 32'd1);
    wait_idle("single");
    chk("single_busy_cycles", busy_cnt, FRAME_BITS * CPB);
    chk("single_busy_runs", busy_falls, 1);
    compare_rx("single");

    // Two back-to-back frames, second byte loaded as soon as THR frees.
    clear_counters();
    load_byte(8'h47);
    exp_q.push_back(8'h47);
    wait_empty("b2b");
    load_byte(8'h45);
    exp_q.push_back(8'h45);
    wait_idle("b2b");
    chk("b2b_busy_cycles", busy_cnt, 2 * FRAME_BITS * CPB);
    chk("b2b_busy_runs", busy_falls, 1);
    chk("b2b_no_overrun", ovr_cnt, 0);
    compare_rx("b2b");

    // Three consecutive loads: 2nd coincides with the transfer, 3rd is dropped.
    clear_counters();
    @(posedge clk);
    #1 ldtxdata = 1'b1; txdata = 8'h41;
    @(posedge clk);
    #1 txdata = 8'h42;
    @(posedge clk);
    #1 txdata = 8'h43;
    @(posedge clk);
    #1 ldtxdata = 1'b0;
    @(negedge clk);
    chk("ovr_pulse_on_third", {31'b0, overrun}, 32'd1);
    @(negedge clk);
    chk("ovr_pulse_one_cycle", {31'b0, overrun}, 32'd0);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    wait_idle("ovr");
    chk("ovr_count", ovr_cnt, 1);
    chk("ovr_busy_cycles", busy_cnt, 2 * FRAME_BITS * CPB);
    compare_rx("ovr");

    // Requester-style stream of 19 random bytes (wait for txempty, load, see it drop).
    clear_counters();
    for (int k = 0; k < 19; k++) begin
      wait_empty("stream");
      repeat ($urandom_range(0, 3)) @(negedge clk);
      b = 8'($urandom_range(0, 255));
      load_byte(b);
      exp_q.push_back(b);
      @(negedge clk);
      chk("stream_txempty_low", {31'b0, txempty}, 32'd0);
    end
    wait_idle("stream");
    chk("stream_busy_cycles", busy_cnt, 19 * FRAME_BITS * CPB);
    chk("stream_busy_runs", busy_falls, 1);
    chk("stream_no_overrun", ovr_cnt, 0);
    compare_rx("stream");

    // Reset during data bit 3 of 0x55 truncates the frame.
    mon_en = 1'b0;
    load_byte(8'h55);
    repeat (2 + 4 * 4 + 1) @(negedge clk);
    chk("rst_mid_bit3_level", {31'b0, tx}, 32'd0);
    chk("rst_mid_busy", {31'b0, txbusy}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx", {31'b0, tx}, 32'd1);
    chk("rst_mid_txempty", {31'b0, txempty}, 32'd1);
    chk("rst_mid_txbusy", {31'b0, txbusy}, 32'd0);
    lows = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1 || txbusy !== 1'b0) lows++;
    end
    chk("rst_mid_quiet", lows, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
